// File: rtl/mem_access_sequencer_if.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer_if
//   Memory-side request/acknowledge bus of the multicycle memory access
//   sequencer.
//
//   Signals:
//     mem_addr   registered address to memory            (sequencer -> memory)
//     mem_wdata  registered store data                    (sequencer -> memory)
//     mem_req    access request, held until mem_ack       (sequencer -> memory)
//     mem_we     write strobe, valid while mem_req=1      (sequencer -> memory)
//     mem_rdata  read data, valid with mem_ack on a read  (memory -> sequencer)
//     mem_ack    single-cycle completion                  (memory -> sequencer)
//
//   Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_access_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer
//   Multicycle memory access sequencer sitting after the PC/ALUOut address
//   mux. Registers the selected address, issues one read or write over a
//   req/ack handshake of variable latency, loads MDR (and optionally IR) on
//   read completion, and reports busy/done to the main control FSM.
//
//   Optional feature: define MEM_TIMEOUT_EN to build an 8-bit ack wait
//   counter; after TIMEOUT_CYCLES ACCESS cycles without ack the access is
//   abandoned with done=err=1. Without the macro err is constant 0 and
//   ACCESS waits indefinitely.
//
//   Ports:
//     clk       system clock, rising edge
//     rst_n     asynchronous active-low reset
//     addr_in   address from the instruction/data address mux
//     wdata_in  store data (register file B operand)
//     start     access request, sampled only in IDLE
//     we_in     1 = write, 0 = read; sampled with start
//     ir_write  on a read also load IR; sampled with start
//     mem       memory bus (mem_access_sequencer_if.master)
//     ir_out    Instruction Register
//     mdr_out   Memory Data Register
//     busy      1 whenever not IDLE
//     done      one-cycle completion pulse
//     err       timeout pulse (0 without MEM_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module mem_access_sequencer #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  addr_in,
    input  logic [DATA_WIDTH-1:0]  wdata_in,
    input  logic                   start,
    input  logic                   we_in,
    input  logic                   ir_write,
    mem_access_sequencer_if.master mem,
    output logic [DATA_WIDTH-1:0]  ir_out,
    output logic [DATA_WIDTH-1:0]  mdr_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state;
    logic   we_lat;
    logic   irw_lat;

    // The wait counter lives in 8 bits, so the limit must fit there.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef MEM_TIMEOUT_EN
    // The count before increment equals the number of ack-less ACCESS
    // cycles already seen, so the limit trips one below TIMEOUT_CYCLES.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            ir_out        <= '0;
            mdr_out       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            we_lat        <= 1'b0;
            irw_lat       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err           <= 1'b0;
            wait_cnt      <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem.mem_addr  <= addr_in;
                        mem.mem_wdata <= wdata_in;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= we_in;
                        we_lat        <= we_in;
                        irw_lat       <= ir_write;
                        busy          <= 1'b1;
                        state         <= ACCESS;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt      <= 8'd0;
`endif
                    end
                end

                ACCESS: begin
                    if (mem.mem_ack) begin
                        // Writes leave IR/MDR alone regardless of ir_write.
                        if (!we_lat) begin
                            mdr_out <= mem.mem_rdata;
                            if (irw_lat) begin
                                ir_out <= mem.mem_rdata;
                            end
                        end
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef MEM_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                end

                default: begin
                    mem.mem_req <= 1'b0;
                    mem.mem_we  <= 1'b0;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr_in;
    logic [31:0] wdata_in;
    logic        start;
    logic        we_in;
    logic        ir_write;
    logic [31:0] ir_out;
    logic [31:0] mdr_out;
    logic        busy;
    logic        done;
    logic        err;

    int total;
    int bad;

    mem_access_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) mif ();

    mem_access_sequencer #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_in (addr_in),
        .wdata_in(wdata_in),
        .start   (start),
        .we_in   (we_in),
        .ir_write(ir_write),
        .mem     (mif),
        .ir_out  (ir_out),
        .mdr_out (mdr_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Full access; inputs change on negedges, outputs checked on negedges.
    task automatic do_access(input logic [15:0] a, input logic [31:0] wd, input logic we,
                             input logic irw, input int waits, input logic [31:0] rd);
        @(negedge clk);
        addr_in = a; wdata_in = wd; we_in = we; ir_write = irw; start = 1'b1;
        @(negedge clk);
        start = 1'b0; addr_in = ~a; wdata_in = ~wd; we_in = ~we;
        for (int i = 0; i <= waits; i++) begin
            check("req_held", mif.mem_req, 1'b1);
            check("addr_held", mif.mem_addr, a);
            check("we_held", mif.mem_we, we);
            if (we) check("wdata_held", mif.mem_wdata, wd);
            check("busy_acc", busy, 1'b1);
            check("done_acc", done, 1'b0);
            if (i == waits) begin
                mif.mem_ack = 1'b1; mif.mem_rdata = rd;
            end
            @(negedge clk);
        end
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
        check("done_pulse", done, 1'b1);
        check("busy_done", busy, 1'b1);
        check("req_drop", mif.mem_req, 1'b0);
        check("err_normal", err, 1'b0);
        @(negedge clk);
        check("done_clr", done, 1'b0);
        check("busy_clr", busy, 1'b0);
    endtask

    initial begin
        int n_done;
        int n_req;
        total = 0; bad = 0;
        rst_n = 1'b0; addr_in = '0; wdata_in = '0; start = 1'b0; we_in = 1'b0; ir_write = 1'b0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;

        repeat (2) @(negedge clk);
        check("rst_req", mif.mem_req, 1'b0);
        check("rst_we", mif.mem_we, 1'b0);
        check("rst_addr", mif.mem_addr, 16'h0);
        check("rst_wdata", mif.mem_wdata, 32'h0);
        check("rst_ir", ir_out, 32'h0);
        check("rst_mdr", mdr_out, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // Zero-wait read loading IR.
        do_access(16'h0040, 32'h0, 1'b0, 1'b1, 0, 32'h8C220004);
        check("t1_ir", ir_out, 32'h8C220004);
        check("t1_mdr", mdr_out, 32'h8C220004);

        // 3-wait read, IR untouched.
        do_access(16'h0080, 32'h0, 1'b0, 1'b0, 3, 32'hDEADBEEF);
        check("t2_mdr", mdr_out, 32'hDEADBEEF);
        check("t2_ir", ir_out, 32'h8C220004);

        // Write with ir_write=1 and junk on rdata: IR/MDR must not move.
        do_access(16'h0100, 32'h12345678, 1'b1, 1'b1, 1, 32'hFFFFFFFF);
        check("t3_ir", ir_out, 32'h8C220004);
        check("t3_mdr", mdr_out, 32'hDEADBEEF);

        // Stray ack in IDLE.
        @(negedge clk);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h55555555;
        @(negedge clk);
        mif.mem_ack = 1'b0;
        check("stray_mdr", mdr_out, 32'hDEADBEEF);
        check("stray_ir", ir_out, 32'h8C220004);
        check("stray_req", mif.mem_req, 1'b0);
        check("stray_done", done, 1'b0);

        // Start held through ACCESS and DONE is ignored; exactly one done.
        addr_in = 16'h0200; we_in = 1'b0; ir_write = 1'b0; start = 1'b1;
        @(negedge clk);
        check("busy_req", mif.mem_req, 1'b1);
        addr_in = 16'h0300;
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        mif.mem_ack = 1'b0;
        check("busy_done", done, 1'b1);
        check("busy_mdr", mdr_out, 32'hA5A5A5A5);
        check("busy_addr", mif.mem_addr, 16'h0200);
        @(negedge clk);
        start = 1'b0;
        n_done = 0; n_req = 0;
        for (int i = 0; i < 4; i++) begin
            mif.mem_ack = (i % 2 == 0);
            if (done) n_done++;
            if (mif.mem_req) n_req++;
            @(negedge clk);
        end
        mif.mem_ack = 1'b0;
        check("busy_extra_done", n_done, 0);
        check("busy_extra_req", n_req, 0);
        check("busy_mdr_hold", mdr_out, 32'hA5A5A5A5);

        // Asynchronous reset in the middle of an access.
        addr_in = 16'h0400; we_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("arst_pre_req", mif.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", mif.mem_req, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_mdr", mdr_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_access(16'h0044, 32'h0, 1'b0, 1'b1, 0, 32'h01234567);
        check("arst_ir", ir_out, 32'h01234567);
        check("arst_mdr2", mdr_out, 32'h01234567);

`ifdef MEM_TIMEOUT_EN
        // No ack: four wait cycles, then done=err=1.
        addr_in = 16'h0500; we_in = 1'b0; ir_write = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_req = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (mif.mem_req) n_req++;
            @(negedge clk);
        end
        check("to_reqcycles", n_req, 4);
        check("to_done", done, 1'b1);
        check("to_err", err, 1'b1);
        check("to_req", mif.mem_req, 1'b0);
        check("to_mdr", mdr_out, 32'h01234567);
        @(negedge clk);
        check("to_err_clr", err, 1'b0);

        // Ack on exactly the limit cycle wins.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("to2_req", mif.mem_req, 1'b1);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mif.mem_ack = 1'b0;
        check("to2_done", done, 1'b1);
        check("to2_err", err, 1'b0);
        check("to2_mdr", mdr_out, 32'hCAFEF00D);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
